bit_alloc_picker: RTL and testbench
===================================

// Module: bit_alloc_picker
// PURPOSE
//  Registered multi-port free-entry allocator over a WIDTH-entry busy bitmap.
//  Each cycle it grants up to NALLOC free entries to requesting slots, using a
//  priority scan from the low or high end, and accepts up to NFREE returns.
//  Generalises the single-shot 64-bit index finder to parametrised width,
//  multiple picks per cycle, scan direction and held state.
//  Sits between the rename/schedule front end and the physical-entry pools.
// PARAMETERS
//  WIDTH   64  number of entries; power of two, 8..256
//  NALLOC  2   allocation slots per cycle, 1..4
//  NFREE   2   free ports per cycle, 1..4
//  HIFIRST 0   0: lowest free index is granted first; 1: highest free index first
//  IDXW    $clog2(WIDTH)  index width (derived; not overridden)
// PORTS
//  clk        in   1             clock, rising edge
//  rst        in   1             asynchronous reset, active high
//  alloc_req  in   NALLOC        per-slot allocation request
//  alloc_vld  out  NALLOC        per-slot grant valid (registered)
//  alloc_idx  out  NALLOC*IDXW   granted index; slot k uses bits [k*IDXW+:IDXW]
//  free_en    in   NFREE         per-port free strobe
//  free_idx   in   NFREE*IDXW    index to free; port k uses bits [k*IDXW+:IDXW]
//  flush      in   1             mark all entries free
//  free_cnt   out  IDXW+1        number of free entries (registered bitmap)
//  hasany     out  1             at least one free entry
//  err        out  1             sticky: a free was issued to an already-free entry
// BEHAVIOUR
//  - State: busy[WIDTH-1:0]. Reset: busy=0, alloc_vld=0, alloc_idx=0, err=0,
//    free_cnt=WIDTH, hasany=1.
//  - Cycle t: picks are taken from busy as registered at the start of t.
//    Requesting slots are compacted in ascending slot order. The j-th requesting
//    slot receives the j-th free entry in scan order (ascending index if
//    HIFIRST=0, descending if 1).
//  - At the t->t+1 edge, alloc_vld/alloc_idx are registered and granted
//    entries become busy. Latency is 1 cycle. An ungranted slot gets
//    alloc_vld=0 and alloc_idx=0; the requester retries.
//  - Fewer free entries than requests: lower-numbered requesting slots win.
//  - Free: busy[free_idx]<=0 at the edge when free_en is set. An entry freed in
//    cycle t is not grantable until cycle t+1 (no bypass).
//  - Duplicate free index across ports in the same cycle is a single free.
//  - Free of an entry with busy=0 (busy taken at the start of t) sets err.
//  - Alloc and free never target the same entry in one cycle, because granted
//    entries come from the free set. A free to an entry whose busy bit is
//    already 0 is an error case (err set) and leaves the entry free.
//  - flush has priority over all other inputs. At the next edge: busy=0 and
//    alloc_vld=0. Free strobes in the same cycle are ignored and do not set
//    err. err itself is cleared only by rst.
//  - free_cnt = popcount(~busy); hasany = |~busy. Both reflect the registered
//    bitmap, not in-flight grants.
//  - Full (busy all ones): all alloc_vld=0. Frees still apply.
//  - rst asserted mid-operation clears all state immediately, asynchronously.
//  - Pick logic: per-slot masked priority encoders. Slot j's encoder sees the
//    free vector with the first j picks removed; no combinational loop.
// TESTING  (WIDTH=64, NALLOC=2, NFREE=2 unless stated)
//  1 After reset, alloc_req=2'b11 for 1 cycle -> next cycle alloc_vld=11,
//    idx0=0, idx1=1; free_cnt=62.
//  2 HIFIRST=1, reset, alloc_req=2'b10 -> alloc_vld=10, idx1=63; alloc_req=2'b11
//    -> idx0=62, idx1=61.
//  3 Fill to 63 busy (only 17 free), alloc_req=11 -> vld=01, idx0=17, hasany=0.
//    Next cycle free idx 5 with alloc_req=01 -> vld=00. Following cycle
//    alloc_req=01 -> idx0=5.
//  4 Free ports 0 and 1 both idx 9 (busy) -> free_cnt +1, err=0. Free idx 9
//    again -> err=1 and stays 1.
//  5 Busy=40 entries, flush with alloc_req=11 and free_en=11 -> next cycle
//    busy=0, alloc_vld=00, free_cnt=64, err unchanged.
//  6 Assert rst mid-stream with grants pending -> outputs at reset values
//    without a clock edge; a random alloc/free soak against a bitmap model
//    shows no double allocation.

Source files
------------

// File: rtl/bit_alloc_picker_if.sv
// Allocator bus: per-slot allocation requests and grants, free strobes, flush and status.
// Carries no state and adds no latency of its own.
// There is no backpressure on this bus: a slot that is not granted simply asks again.
interface bit_alloc_picker_if #(
  parameter int WIDTH  = 64,
  parameter int NALLOC = 2,
  parameter int NFREE  = 2
);
  localparam int IDXW = $clog2(WIDTH);

  logic [NALLOC-1:0]      alloc_req;
  logic [NALLOC-1:0]      alloc_vld;
  logic [NALLOC*IDXW-1:0] alloc_idx;
  logic [NFREE-1:0]       free_en;
  logic [NFREE*IDXW-1:0]  free_idx;
  logic                   flush;
  logic [IDXW:0]          free_cnt;
  logic                   hasany;
  logic                   err;

  // Requester / front-end side
  modport master (
    output alloc_req, free_en, free_idx, flush,
    input  alloc_vld, alloc_idx, free_cnt, hasany, err
  );

  // Allocator side
  modport slave (
    input  alloc_req, free_en, free_idx, flush,
    output alloc_vld, alloc_idx, free_cnt, hasany, err
  );
endinterface

// File: rtl/bit_alloc_picker.sv
// Multi-port free-entry allocator over a busy bitmap; grants up to NALLOC entries per cycle.
// Grants are registered with 1-cycle latency; free_cnt and hasany follow the registered bitmap.
// No backpressure: an ungranted slot sees alloc_vld=0 and retries; a flush drops all grants.
module bit_alloc_picker #(
  parameter int WIDTH   = 64,
  parameter int NALLOC  = 2,
  parameter int NFREE   = 2,
  parameter int HIFIRST = 0
) (
  input  logic               clk,
  input  logic               rst,
  bit_alloc_picker_if.slave  bus
);
  localparam int IDXW = $clog2(WIDTH);
  localparam int RW   = (NALLOC > 1) ? $clog2(NALLOC) : 1;

  logic [WIDTH-1:0]       busy;
  logic [WIDTH-1:0]       pick_pool;
  logic [NALLOC-1:0]      pick_vld;
  logic [IDXW-1:0]        pick_idx [NALLOC];
  logic [RW-1:0]          rank;
  logic [NALLOC-1:0]      gnt_vld;
  logic [NALLOC*IDXW-1:0] gnt_idx;
  logic [WIDTH-1:0]       grant_mask;
  logic [WIDTH-1:0]       free_mask;
  logic                   err_set;
  logic [NALLOC-1:0]      vld_q;
  logic [NALLOC*IDXW-1:0] idx_q;
  logic                   err_q;
  logic [IDXW:0]          cnt;

  // Returns the first set bit in scan order: lowest index, or highest when HIFIRST is set.
  function automatic logic [IDXW-1:0] first_free(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] r;
    r = '0;
    if (HIFIRST != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) r = IDXW'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (v[i]) r = IDXW'(i);
      end
    end
    return r;
  endfunction

  // Chained priority encoders: pick j sees the free set with picks 0..j-1 removed.
  always_comb begin
    pick_pool = ~busy;
    for (int j = 0; j < NALLOC; j++) begin
      pick_vld[j] = |pick_pool;
      pick_idx[j] = first_free(pick_pool);
      if (pick_vld[j]) pick_pool[pick_idx[j]] = 1'b0;
    end
  end

  // Requesting slots are compacted in slot order; the j-th requester takes pick j.
  always_comb begin
    rank       = '0;
    gnt_vld    = '0;
    gnt_idx    = '0;
    grant_mask = '0;
    for (int k = 0; k < NALLOC; k++) begin
      if (bus.alloc_req[k]) begin
        if (pick_vld[rank]) begin
          gnt_vld[k]                   = 1'b1;
          gnt_idx[k*IDXW +: IDXW]      = pick_idx[rank];
          grant_mask[pick_idx[rank]]   = 1'b1;
        end
        rank = rank + RW'(1);
      end
    end
  end

  // Merge free ports into one mask (duplicates collapse) and flag frees of idle entries.
  always_comb begin
    free_mask = '0;
    for (int p = 0; p < NFREE; p++) begin
      if (bus.free_en[p]) free_mask[bus.free_idx[p*IDXW +: IDXW]] = 1'b1;
    end
    err_set = |(free_mask & ~busy);
  end

  // Population count of free entries in the registered bitmap.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{IDXW{1'b0}}, ~busy[i]};
    end
  end

  // Bitmap update: flush clears everything; otherwise frees clear and grants set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (bus.flush) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~free_mask) | grant_mask;
    end
  end

  // Registered grant outputs; a flush cycle returns no grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      idx_q <= '0;
    end else if (bus.flush) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= gnt_vld;
      idx_q <= gnt_idx;
    end
  end

  // Sticky error on a free of an already-free entry; frees during flush are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (!bus.flush && err_set) begin
      err_q <= 1'b1;
    end
  end

  assign bus.alloc_vld = vld_q;
  assign bus.alloc_idx = idx_q;
  assign bus.free_cnt  = cnt;
  assign bus.hasany    = |(~busy);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_bit_alloc_picker.sv
// Directed and soak bench for bit_alloc_picker, low-first and high-first instances.
// Checks sample 1 time unit after the rising edge; inputs change at the same point.
// No backpressure exists on the bus; grants are compared against hand values and a bitmap model.
module tb_bit_alloc_picker;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  bit_alloc_picker_if #(.WIDTH(64), .NALLOC(2), .NFREE(2)) bi0 ();
  bit_alloc_picker_if #(.WIDTH(64), .NALLOC(2), .NFREE(2)) bi1 ();

  bit_alloc_picker #(.WIDTH(64), .NALLOC(2), .NFREE(2), .HIFIRST(0))
    dut0 (.clk(clk), .rst(rst), .bus(bi0));
  bit_alloc_picker #(.WIDTH(64), .NALLOC(2), .NFREE(2), .HIFIRST(1))
    dut1 (.clk(clk), .rst(rst), .bus(bi1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [1:0] fen;
    logic [5:0] f0;
    logic [5:0] f1;
    logic       fl;
    logic [1:0] vld;
    logic [5:0] i0;
    logic [5:0] i1;
    logic [6:0] cnt;
    logic       err;
  } vec_t;

  vec_t tv [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic [1:0] req, input logic [1:0] fen,
                      input logic [5:0] f0, input logic [5:0] f1, input logic fl);
    bi0.alloc_req = req;
    bi0.free_en   = fen;
    bi0.free_idx  = {f1, f0};
    bi0.flush     = fl;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  logic [63:0] mbusy;
  logic [63:0] nbusy;
  logic [63:0] avail;
  logic [1:0]  ev;
  logic [5:0]  ei [2];
  logic [1:0]  rq;
  logic [1:0]  fe;
  logic [5:0]  fi [2];
  logic [5:0]  di;
  logic        found;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drv0(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    bi1.alloc_req = '0;
    bi1.free_en   = '0;
    bi1.free_idx  = '0;
    bi1.flush     = 1'b0;
    #12;
    // reset state
    chk("rst_vld",  bi0.alloc_vld, 2'b00);
    chk("rst_idx",  bi0.alloc_idx, 12'd0);
    chk("rst_cnt",  bi0.free_cnt, 7'd64);
    chk("rst_any",  bi0.hasany, 1'b1);
    chk("rst_err",  bi0.err, 1'b0);
    rst = 1'b0;
    #2;

    // high-first instance
    bi1.alloc_req = 2'b10;
    tick();
    chk("hi_vld_a", bi1.alloc_vld, 2'b10);
    chk("hi_idx_a", bi1.alloc_idx, {6'd63, 6'd0});
    bi1.alloc_req = 2'b11;
    tick();
    chk("hi_vld_b", bi1.alloc_vld, 2'b11);
    chk("hi_idx_b", bi1.alloc_idx, {6'd61, 6'd62});
    chk("hi_cnt_b", bi1.free_cnt, 7'd61);
    bi1.alloc_req = 2'b00;

    // table of low-first vectors starting from an empty bitmap
    tv[0] = '{2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 2'b11, 6'd0, 6'd1, 7'd62, 1'b0};
    tv[1] = '{2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 2'b01, 6'd2, 6'd0, 7'd61, 1'b0};
    tv[2] = '{2'b10, 2'b00, 6'd0, 6'd0, 1'b0, 2'b10, 6'd0, 6'd3, 7'd60, 1'b0};
    tv[3] = '{2'b00, 2'b11, 6'd1, 6'd1, 1'b0, 2'b00, 6'd0, 6'd0, 7'd61, 1'b0};
    tv[4] = '{2'b11, 2'b01, 6'd2, 6'd0, 1'b0, 2'b11, 6'd1, 6'd4, 7'd60, 1'b0};
    tv[5] = '{2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 2'b11, 6'd2, 6'd5, 7'd58, 1'b0};
    for (int v = 0; v < 6; v++) begin
      drv0(tv[v].req, tv[v].fen, tv[v].f0, tv[v].f1, tv[v].fl);
      tick();
      chk($sformatf("tv%0d_vld", v), bi0.alloc_vld, tv[v].vld);
      chk($sformatf("tv%0d_idx", v), bi0.alloc_idx, {tv[v].i1, tv[v].i0});
      chk($sformatf("tv%0d_cnt", v), bi0.free_cnt, tv[v].cnt);
      chk($sformatf("tv%0d_any", v), bi0.hasany, 1'b1);
      chk($sformatf("tv%0d_err", v), bi0.err, tv[v].err);
    end
    drv0(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);

    // fill completely, leave only entry 17 free, then exhaust and refill
    pulse_rst();
    drv0(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    for (int c = 0; c < 32; c++) tick();
    chk("fill_cnt", bi0.free_cnt, 7'd0);
    chk("fill_any", bi0.hasany, 1'b0);
    chk("fill_idx", bi0.alloc_idx, {6'd63, 6'd62});
    drv0(2'b00, 2'b01, 6'd17, 6'd0, 1'b0);
    tick();
    chk("one_cnt", bi0.free_cnt, 7'd1);
    chk("one_any", bi0.hasany, 1'b1);
    drv0(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    chk("last_vld", bi0.alloc_vld, 2'b01);
    chk("last_idx", bi0.alloc_idx, {6'd0, 6'd17});
    chk("last_any", bi0.hasany, 1'b0);
    drv0(2'b01, 2'b01, 6'd5, 6'd0, 1'b0);
    tick();
    chk("nobyp_vld", bi0.alloc_vld, 2'b00);
    chk("nobyp_cnt", bi0.free_cnt, 7'd1);
    drv0(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    chk("reuse_vld", bi0.alloc_vld, 2'b01);
    chk("reuse_idx", bi0.alloc_idx, {6'd0, 6'd5});
    chk("reuse_cnt", bi0.free_cnt, 7'd0);

    // flush with 40 busy, concurrent requests and frees of idle entries
    pulse_rst();
    drv0(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    for (int c = 0; c < 20; c++) tick();
    chk("b40_cnt", bi0.free_cnt, 7'd24);
    drv0(2'b11, 2'b11, 6'd50, 6'd51, 1'b1);
    tick();
    chk("flush_vld", bi0.alloc_vld, 2'b00);
    chk("flush_cnt", bi0.free_cnt, 7'd64);
    chk("flush_err", bi0.err, 1'b0);
    drv0(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    chk("postfl_idx", bi0.alloc_idx, {6'd1, 6'd0});
    chk("postfl_cnt", bi0.free_cnt, 7'd62);

    // duplicate free, then double free sets sticky err
    drv0(2'b00, 2'b11, 6'd1, 6'd1, 1'b0);
    tick();
    chk("dup_cnt", bi0.free_cnt, 7'd63);
    chk("dup_err", bi0.err, 1'b0);
    drv0(2'b00, 2'b01, 6'd1, 6'd0, 1'b0);
    tick();
    chk("dbl_err", bi0.err, 1'b1);
    chk("dbl_cnt", bi0.free_cnt, 7'd63);
    drv0(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    chk("stick_err", bi0.err, 1'b1);
    drv0(2'b00, 2'b00, 6'd0, 6'd0, 1'b1);
    tick();
    chk("flerr_err", bi0.err, 1'b1);
    chk("flerr_cnt", bi0.free_cnt, 7'd64);

    // asynchronous reset with grants pending
    drv0(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    chk("pend_vld", bi0.alloc_vld, 2'b11);
    drv0(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld", bi0.alloc_vld, 2'b00);
    chk("arst_idx", bi0.alloc_idx, 12'd0);
    chk("arst_cnt", bi0.free_cnt, 7'd64);
    chk("arst_any", bi0.hasany, 1'b1);
    chk("arst_err", bi0.err, 1'b0);
    #3;
    rst = 1'b0;

    // random soak against a bitmap model
    mbusy = '0;
    for (int c = 0; c < 300; c++) begin
      rq = 2'($urandom_range(3));
      fe = 2'b00;
      for (int p = 0; p < 2; p++) begin
        fi[p] = 6'($urandom_range(63));
        if (mbusy[fi[p]] && ($urandom_range(1) == 1)) fe[p] = 1'b1;
      end
      avail = ~mbusy;
      ev    = 2'b00;
      for (int k = 0; k < 2; k++) begin
        ei[k] = 6'd0;
        if (rq[k]) begin
          found = 1'b0;
          for (int i = 0; i < 64; i++) begin
            if (!found && avail[i]) begin
              found  = 1'b1;
              ev[k]  = 1'b1;
              ei[k]  = 6'(i);
            end
          end
          if (found) avail[ei[k]] = 1'b0;
        end
      end
      nbusy = mbusy;
      for (int p = 0; p < 2; p++) if (fe[p]) nbusy[fi[p]] = 1'b0;
      for (int k = 0; k < 2; k++) if (ev[k]) nbusy[ei[k]] = 1'b1;
      drv0(rq, fe, fi[0], fi[1], 1'b0);
      tick();
      chk("soak_vld", bi0.alloc_vld, ev);
      chk("soak_idx", bi0.alloc_idx, {ei[1], ei[0]});
      chk("soak_cnt", bi0.free_cnt, 7'(64 - $countones(nbusy)));
      for (int k = 0; k < 2; k++) begin
        if (bi0.alloc_vld[k]) begin
          di = bi0.alloc_idx[k*6 +: 6];
          chk("soak_dblalloc", mbusy[di], 1'b0);
        end
      end
      mbusy = nbusy;
    end
    drv0(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    chk("soak_err", bi0.err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
